sha3_absorb_ctrl: RTL

Byte-stream sequencer for the SHA3-256 core (`SHA3TOP`) that lifts the single-block limit of the top-level byte interface. It packs an arbitrary-length message (≥1 byte) into 1088-bit rate blocks and applies SHA3 padding. It drives the core's `in_valid`/`more` handshake block by block, waiting on `hash_next` between blocks. It then serializes the 256-bit digest as 32 output bytes.

---
 rtl/sha3_pkg.sv | 34 +++
 rtl/sha3_digest_ser.sv | 46 ++++
 rtl/sha3_absorb_ctrl.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/sha3_pkg.sv
// Shared constants, state encoding and bit-order helper for the SHA3 absorb path.
package sha3_pkg;

  localparam int RATE_BYTES   = 136;
  localparam int DIGEST_BYTES = 32;
  localparam int RATE_BITS    = RATE_BYTES * 8;
  localparam int DIGEST_BITS  = DIGEST_BYTES * 8;

  // Padding bytes already in the core's reversed bit order (0x06 and 0x80 of FIPS 202).
  localparam logic [7:0] SHA3_DS_BYTE  = 8'h60;
  localparam logic [7:0] SHA3_END_BYTE = 8'h01;

  localparam logic [7:0] LAST_SLOT = 8'(RATE_BYTES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_ISSUE,
    ST_WAIT_NEXT,
    ST_PADBLK,
    ST_WAIT_HASH,
    ST_OUT
  } absorb_state_t;

  // The core expects bit 0 of each message byte in the MSB of its slot.
  function automatic logic [7:0] bit_rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) begin
      r[i] = b[7-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/sha3_digest_ser.sv
// Digest serializer: latches the 256-bit digest and emits it LSB byte first,
// one byte per cycle, flagging the final byte.
module sha3_digest_ser
  import sha3_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load,
  input  logic [DIGEST_BITS-1:0] din,
  output logic [7:0]             o_data,
  output logic                   o_valid,
  output logic                   o_last
);

  localparam int IDX_W = $clog2(DIGEST_BYTES);

  logic [DIGEST_BITS-1:0] shift_reg;
  logic [IDX_W-1:0]       idx_reg;

  // Load emits byte 0 immediately; each following cycle shifts out the next byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg <= '0;
      idx_reg   <= '0;
      o_data    <= 8'h00;
      o_valid   <= 1'b0;
      o_last    <= 1'b0;
    end else if (load) begin
      o_data    <= din[7:0];
      o_valid   <= 1'b1;
      o_last    <= 1'b0;
      shift_reg <= {8'h00, din[DIGEST_BITS-1:8]};
      idx_reg   <= IDX_W'(1);
    end else if (o_valid && !o_last) begin
      o_data    <= shift_reg[7:0];
      shift_reg <= {8'h00, shift_reg[DIGEST_BITS-1:8]};
      o_last    <= (idx_reg == IDX_W'(DIGEST_BYTES - 1));
      idx_reg   <= idx_reg + IDX_W'(1);
    end else begin
      o_data  <= 8'h00;
      o_valid <= 1'b0;
      o_last  <= 1'b0;
    end
  end

endmodule

// File: rtl/sha3_absorb_ctrl.sv
// Byte-stream front end for the SHA3-256 core: packs bytes into rate blocks,
// inserts SHA3 padding, sequences multi-block absorption and serializes the digest.
module sha3_absorb_ctrl
  import sha3_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [7:0]             i_data,
  input  logic                   i_valid,
  input  logic                   i_last,
  output logic                   o_in_ready,
  output logic [7:0]             o_data,
  output logic                   o_valid,
  output logic                   o_last,
  output logic [RATE_BITS-1:0]   core_in,
  output logic                   core_more,
  output logic                   core_in_valid,
  input  logic                   core_hash_next,
  input  logic [DIGEST_BITS-1:0] core_out,
  input  logic                   core_out_valid
);

  absorb_state_t state;
  logic [7:0]    cnt;
  logic          pad_pending;

  logic          accept;
  logic          at_end;
  logic [7:0]    cnt_inc;
  logic [7:0]    data_rev;
  logic          buf_clear;
  logic          buf_pad;
  logic          ser_load;

  // o_in_ready is only high in IDLE/FILL, so it doubles as the accept qualifier.
  assign accept    = i_valid && o_in_ready;
  assign at_end    = (cnt == LAST_SLOT);
  assign cnt_inc   = cnt + 8'd1;
  assign data_rev  = bit_rev8(i_data);
  assign buf_clear = ((state == ST_WAIT_NEXT) && core_hash_next) ||
                     ((state == ST_OUT) && o_last);
  assign buf_pad   = (state == ST_PADBLK);
  assign ser_load  = (state == ST_WAIT_HASH) && core_out_valid;

  // One byte slot per rate byte; slot k maps to core_in[1087-8k -: 8].
  for (genvar gi = 0; gi < RATE_BYTES; gi++) begin : g_slot
    localparam logic [7:0] SLOT_IDX = 8'(gi);
    localparam bit         IS_END   = (gi == RATE_BYTES - 1);
    localparam logic [7:0] PAD_VAL  = (gi == 0) ? SHA3_DS_BYTE :
                                      (IS_END ? SHA3_END_BYTE : 8'h00);

    logic [7:0] slot_reg;
    logic [7:0] fill_val;

    // Value this slot takes on an accepted byte: the byte itself, plus padding
    // when the message ends here (the end marker only if this block closes it).
    always_comb begin
      fill_val = slot_reg;
      if (cnt == SLOT_IDX) begin
        fill_val = data_rev;
      end
      if (i_last && (cnt_inc == SLOT_IDX)) begin
        fill_val = fill_val | SHA3_DS_BYTE;
      end
      if (i_last && !at_end && IS_END) begin
        fill_val = fill_val | SHA3_END_BYTE;
      end
    end

    // Slot register: cleared between blocks, preset for the padding-only block.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        slot_reg <= 8'h00;
      end else if (buf_clear) begin
        slot_reg <= 8'h00;
      end else if (buf_pad) begin
        slot_reg <= PAD_VAL;
      end else if (accept) begin
        slot_reg <= fill_val;
      end
    end

    assign core_in[RATE_BITS-1-8*gi -: 8] = slot_reg;
  end

  // Block sequencing FSM with registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      cnt           <= 8'd0;
      pad_pending   <= 1'b0;
      o_in_ready    <= 1'b1;
      core_more     <= 1'b0;
      core_in_valid <= 1'b0;
    end else begin
      core_in_valid <= 1'b0;
      case (state)
        ST_IDLE, ST_FILL: begin
          if (accept) begin
            if (i_last || at_end) begin
              state         <= ST_ISSUE;
              cnt           <= 8'd0;
              o_in_ready    <= 1'b0;
              core_in_valid <= 1'b1;
              // A full block always has something after it: more data or the pad block.
              core_more     <= at_end;
              pad_pending   <= i_last && at_end;
            end else begin
              state <= ST_FILL;
              cnt   <= cnt_inc;
            end
          end
        end
        ST_ISSUE: begin
          state <= core_more ? ST_WAIT_NEXT : ST_WAIT_HASH;
        end
        ST_WAIT_NEXT: begin
          if (core_hash_next) begin
            cnt <= 8'd0;
            if (pad_pending) begin
              state <= ST_PADBLK;
            end else begin
              state      <= ST_FILL;
              o_in_ready <= 1'b1;
            end
          end
        end
        ST_PADBLK: begin
          state         <= ST_ISSUE;
          core_in_valid <= 1'b1;
          core_more     <= 1'b0;
          pad_pending   <= 1'b0;
        end
        ST_WAIT_HASH: begin
          if (core_out_valid) begin
            state <= ST_OUT;
          end
        end
        ST_OUT: begin
          if (o_last) begin
            state      <= ST_IDLE;
            o_in_ready <= 1'b1;
          end
        end
        default: begin
          state      <= ST_IDLE;
          o_in_ready <= 1'b1;
        end
      endcase
    end
  end

  sha3_digest_ser u_digest_ser (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (ser_load),
    .din     (core_out),
    .o_data  (o_data),
    .o_valid (o_valid),
    .o_last  (o_last)
  );

endmodule
